// File: rtl/membus_pkg.sv
// membus_pkg: shared definitions for the CPU memory bus target.
//   - Address constants of the memory-mapped peripherals.
//   - UART transmitter FSM state codes.
//   - Address decode helper used by the bus logic.
package membus_pkg;

  localparam logic [15:0] MEM_UART_DATA   = 16'h8000;
  localparam logic [15:0] MEM_UART_STATUS = 16'h8004;
  localparam logic [15:0] MEM_CYCLES      = 16'h8008;

  typedef enum logic [1:0] {
    UT_IDLE  = 2'd0,
    UT_START = 2'd1,
    UT_DATA  = 2'd2,
    UT_STOP  = 2'd3
  } ut_state_e;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_UART_DATA,
    SEL_UART_STATUS,
    SEL_CYCLES,
    SEL_NONE
  } sel_e;

  // Word-granular decode: the lower half of the map is RAM, the upper half
  // holds three word registers, everything else is unmapped.
  function automatic sel_e decode(input logic [15:2] word_addr);
    sel_e sel;
    sel = SEL_NONE;
    if (!word_addr[15]) begin
      sel = SEL_RAM;
    end else if (word_addr == MEM_UART_DATA[15:2]) begin
      sel = SEL_UART_DATA;
    end else if (word_addr == MEM_UART_STATUS[15:2]) begin
      sel = SEL_UART_STATUS;
    end else if (word_addr == MEM_CYCLES[15:2]) begin
      sel = SEL_CYCLES;
    end
    return sel;
  endfunction

endpackage

// File: rtl/membus_uart_tx.sv
// uart_tx: 8N1 serial transmitter with a valid/ready byte input.
//   clk, rst   : clock, synchronous active-high reset
//   data/valid : byte offered by the FIFO
//   ready      : byte is accepted this cycle when valid && ready
//   tx         : registered serial line, idles high
//   busy       : a frame is in progress
module uart_tx
  import membus_pkg::*;
#(
  parameter int CLK_DIV = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

  ut_state_e         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              baud_last;

  assign baud_last = (baud_cnt == BAUD_LAST);

  // Accepting in the last cycle of the stop bit lets frames run back to back
  // without an idle cycle between them.
  assign ready = (state == UT_IDLE) || (state == UT_STOP && baud_last);
  assign busy  = (state != UT_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UT_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      baud_cnt <= baud_last ? '0 : baud_cnt + BAUD_W'(1);
      case (state)
        UT_IDLE: begin
          baud_cnt <= '0;
          if (valid) begin
            shreg <= data;
            tx    <= 1'b0;
            state <= UT_START;
          end
        end
        UT_START: begin
          if (baud_last) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= UT_DATA;
          end
        end
        UT_DATA: begin
          if (baud_last) begin
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= UT_STOP;
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        UT_STOP: begin
          if (baud_last) begin
            if (valid) begin
              shreg <= data;
              tx    <= 1'b0;
              state <= UT_START;
            end else begin
              state <= UT_IDLE;
            end
          end
        end
        default: state <= UT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/membus.sv
// membus: memory bus target for the cpu core.
//   clk, rst            : clock, synchronous active-high reset
//   ren, wen            : read / write request (write wins when both are set)
//   addr                : byte address, bits [1:0] ignored
//   wdata, wmask        : write data; wmask[3-k] enables byte k (wdata[8k+7:8k])
//   rdata, rd_valid     : registered read response, one cycle after ren
//   uart_tx             : 8N1 serial output, idles high
// Map: RAM 0x0000-0x7FFF (aliased modulo RAM_WORDS), UART_DATA 0x8000,
// UART_STATUS 0x8004 {29'b0, overflow, fifo_full, tx_busy}, CYCLES 0x8008.
module membus
  import membus_pkg::*;
#(
  parameter int RAM_WORDS  = 8192,
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ren,
  input  logic [15:0] addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic [31:0] rdata,
  output logic        rd_valid,
  output logic        uart_tx
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  sel_e              sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              rd_acc;
  logic              unused_addr_bits;

  assign sel              = decode(addr[15:2]);
  assign ram_idx          = addr[RAM_AW+1:2];
  assign rd_acc           = ren && !wen;
  assign unused_addr_bits = ^addr[1:0];

  // ---------------- RAM ----------------
  logic [31:0] mem [RAM_WORDS];

  // NOTE: storage arrays are deliberately left out of reset so they can map
  // onto RAM macros; only control state is reset.
  always_ff @(posedge clk) begin
    if (wen && sel == SEL_RAM) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask[3-k]) mem[ram_idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // ---------------- TX FIFO ----------------
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic           fifo_empty, fifo_full;
  logic           push_req, push, pop;
  logic           tx_ready, tx_active, tx_busy;
  logic           overflow;
  logic           status_rd;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push_req   = wen && sel == SEL_UART_DATA && wmask[3];
  assign pop        = tx_ready && !fifo_empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign push       = push_req && (!fifo_full || pop);
  assign tx_busy    = tx_active || !fifo_empty;
  assign status_rd  = rd_acc && sel == SEL_UART_STATUS;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      // A dropped byte in the same cycle as a status read keeps the flag set.
      if (push_req && !push) overflow <= 1'b1;
      else if (status_rd)    overflow <= 1'b0;
    end
  end

  uart_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_uart_tx (
    .clk  (clk),
    .rst  (rst),
    .data (fifo_mem[rd_ptr[PTR_W-1:0]]),
    .valid(!fifo_empty),
    .ready(tx_ready),
    .tx   (uart_tx),
    .busy (tx_active)
  );

  // ---------------- cycle counter ----------------
  logic [31:0] cycles;

  always_ff @(posedge clk) begin
    if (rst) cycles <= '0;
    else     cycles <= cycles + 32'd1;
  end

  // ---------------- read path ----------------
  logic [31:0] rd_word;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    rd_word = '0;
    case (sel)
      SEL_RAM:         rd_word = mem[ram_idx];
      SEL_UART_STATUS: rd_word = {29'b0, overflow, fifo_full, tx_busy};
      SEL_CYCLES:      rd_word = cycles;
      default:         rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_membus.sv
module tb_membus;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int RAM_WORDS  = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic [31:0] rdata;
  logic        rd_valid;
  logic        uart_tx;

  membus #(
    .RAM_WORDS (RAM_WORDS),
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ren     (ren),
    .addr    (addr),
    .wen     (wen),
    .wdata   (wdata),
    .wmask   (wmask),
    .rdata   (rdata),
    .rd_valid(rd_valid),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       mon_en = 1'b1;
  logic [7:0] frames_q[$];

  typedef struct {
    string       name;
    logic        ren;
    logic        wen;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        exp_valid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic r, logic w, logic [15:0] a,
                              logic [31:0] d, logic [3:0] m, logic ev,
                              logic [31:0] er);
    vec_t v;
    v.name = n; v.ren = r; v.wen = w; v.addr = a; v.wdata = d; v.wmask = m;
    v.exp_valid = ev; v.exp_rdata = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic r, input logic w, input logic [15:0] a,
                     input logic [31:0] d, input logic [3:0] m);
    ren = r; wen = w; addr = a; wdata = d; wmask = m;
  endtask

  // Frame decoder: samples each bit in its middle on the falling clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst && uart_tx === 1'b0) begin
        logic [7:0] b;
        repeat (CLK_DIV / 2) @(negedge clk);
        check("mon_start_bit", {31'b0, uart_tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        check("mon_stop_bit", {31'b0, uart_tx}, 32'd1);
        frames_q.push_back(b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame_bits;
    int         waited;
    int         lows;

    // ---------------- reset values ----------------
    repeat (3) cyc();
    check("reset_rdata", rdata, 32'd0);
    check("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("reset_uart_tx", {31'b0, uart_tx}, 32'd1);
    rst = 1'b0;

    // ---------------- table-driven bus vectors ----------------
    vecs.push_back(mk("wr_word",      0, 1, 16'h0010, 32'hDEADBEEF, 4'b1111, 0, 32'h0));
    vecs.push_back(mk("rd_word",      1, 0, 16'h0010, 32'h0,        4'b0000, 1, 32'hDEADBEEF));
    vecs.push_back(mk("valid_pulse",  0, 0, 16'h0000, 32'h0,        4'b0000, 0, 32'hDEADBEEF));
    vecs.push_back(mk("wr_zero",      0, 1, 16'h0020, 32'h0,        4'b1111, 0, 32'hDEADBEEF));
    vecs.push_back(mk("wr_byte0",     0, 1, 16'h0020, 32'h00000011, 4'b1000, 0, 32'hDEADBEEF));
    vecs.push_back(mk("wr_byte3",     0, 1, 16'h0023, 32'h44000000, 4'b0001, 0, 32'hDEADBEEF));
    vecs.push_back(mk("rd_bytes",     1, 0, 16'h0020, 32'h0,        4'b0000, 1, 32'h44000011));
    vecs.push_back(mk("rd_b2b",       1, 0, 16'h0010, 32'h0,        4'b0000, 1, 32'hDEADBEEF));
    vecs.push_back(mk("rw_same",      1, 1, 16'h0030, 32'h12345678, 4'b1111, 0, 32'hDEADBEEF));
    vecs.push_back(mk("rd_after_rw",  1, 0, 16'h0030, 32'h0,        4'b0000, 1, 32'h12345678));
    vecs.push_back(mk("rd_unmapped",  1, 0, 16'h9000, 32'h0,        4'b0000, 1, 32'h0));
    vecs.push_back(mk("wr_alias0",    0, 1, 16'h0400, 32'hCAFEF00D, 4'b1111, 0, 32'h0));
    vecs.push_back(mk("rd_alias0",    1, 0, 16'h0000, 32'h0,        4'b0000, 1, 32'hCAFEF00D));
    vecs.push_back(mk("wr_top",       0, 1, 16'h7FFC, 32'h0BADF00D, 4'b1111, 0, 32'hCAFEF00D));
    vecs.push_back(mk("rd_alias_top", 1, 0, 16'h03FC, 32'h0,        4'b0000, 1, 32'h0BADF00D));
    vecs.push_back(mk("wr_cycles",    0, 1, 16'h8008, 32'hFFFFFFFF, 4'b1111, 0, 32'h0BADF00D));
    vecs.push_back(mk("rd_uart_data", 1, 0, 16'h8000, 32'h0,        4'b0000, 1, 32'h0));
    vecs.push_back(mk("rd_status0",   1, 0, 16'h8004, 32'h0,        4'b0000, 1, 32'h0));
    vecs.push_back(mk("wr_mid_bytes", 0, 1, 16'h0010, 32'hAABBCCDD, 4'b0110, 0, 32'h0));
    vecs.push_back(mk("rd_mid_bytes", 1, 0, 16'h0010, 32'h0,        4'b0000, 1, 32'hDEBBCCEF));

    foreach (vecs[i]) begin
      bus(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
      cyc();
      check({vecs[i].name, "_valid"}, {31'b0, rd_valid}, {31'b0, vecs[i].exp_valid});
      check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
    end
    bus(0, 0, 16'h0, 32'h0, 4'h0);
    cyc();

    // ---------------- single frame, exact bit timing ----------------
    frame_bits = {1'b1, 8'h55, 1'b0};
    bus(0, 1, 16'h8000, 32'h00000055, 4'b1000);
    cyc();
    check("frame_pre_idle", {31'b0, uart_tx}, 32'd1);
    bus(1, 0, 16'h8004, 32'h0, 4'h0);       // status while byte waits in FIFO
    cyc();
    bus(0, 0, 16'h0, 32'h0, 4'h0);
    check("frame_status_busy", rdata, 32'h1);
    check("frame_bit_s0", {31'b0, uart_tx}, {31'b0, frame_bits[0]});
    for (int s = 1; s < 10 * CLK_DIV; s++) begin
      cyc();
      check($sformatf("frame_bit_s%0d", s), {31'b0, uart_tx},
            {31'b0, frame_bits[s / CLK_DIV]});
    end
    cyc();
    check("frame_post_idle", {31'b0, uart_tx}, 32'd1);
    bus(1, 0, 16'h8004, 32'h0, 4'h0);
    cyc();
    bus(0, 0, 16'h0, 32'h0, 4'h0);
    check("frame_status_done", rdata, 32'h0);
    repeat (5) cyc();

    // ---------------- overflow with nine pushes during a frame ----------------
    frames_q.delete();
    bus(0, 1, 16'h8000, 32'h000000A0, 4'b1000);
    cyc();
    bus(0, 0, 16'h0, 32'h0, 4'h0);
    repeat (2) cyc();
    for (int i = 1; i <= 9; i++) begin
      bus(0, 1, 16'h8000, 32'h000000A0 + i, 4'b1000);
      cyc();
    end
    bus(1, 0, 16'h8004, 32'h0, 4'h0);
    cyc();
    check("ovf_status_first", rdata, 32'h7);
    cyc();
    bus(0, 0, 16'h0, 32'h0, 4'h0);
    check("ovf_status_second", rdata, 32'h3);

    waited = 0;
    while (frames_q.size() < 9 && waited < 600) begin
      cyc();
      waited++;
    end
    repeat (60) cyc();
    check("ovf_frame_count", frames_q.size(), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < frames_q.size())
        check($sformatf("ovf_frame%0d", i), {24'b0, frames_q[i]}, 32'hA0 + i);
    end
    bus(1, 0, 16'h8004, 32'h0, 4'h0);
    cyc();
    bus(0, 0, 16'h0, 32'h0, 4'h0);
    check("ovf_status_drained", rdata, 32'h0);

    // ---------------- reset in the middle of a frame ----------------
    mon_en = 1'b0;
    bus(0, 1, 16'h8000, 32'h00000000, 4'b1000);
    cyc();
    bus(0, 0, 16'h0, 32'h0, 4'h0);
    repeat (10) cyc();
    check("rst_mid_frame_low", {31'b0, uart_tx}, 32'd0);
    rst = 1'b1;
    bus(1, 0, 16'h0010, 32'h0, 4'h0);
    cyc();
    rst = 1'b0;
    check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    bus(1, 0, 16'h8008, 32'h0, 4'h0);
    cyc();
    check("rst_cycles0", rdata, 32'd0);
    bus(1, 0, 16'h8004, 32'h0, 4'h0);
    cyc();
    check("rst_status", rdata, 32'd0);
    bus(0, 1, 16'h8008, 32'h00000100, 4'b1111);
    cyc();
    check("cycles_wr_no_valid", {31'b0, rd_valid}, 32'd0);
    bus(1, 0, 16'h8008, 32'h0, 4'h0);
    cyc();
    check("cycles_count3", rdata, 32'd3);
    bus(0, 0, 16'h0, 32'h0, 4'h0);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (uart_tx !== 1'b1) lows++;
    end
    check("rst_line_stays_idle", lows, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
